roi_frame_buffer: RTL
=====================

# roi_frame_buffer

Ping-pong frame store directly downstream of the ROI cropper. It accepts cropped pixel write strobes, addresses and pixel data, and fills one bank with a complete ROI frame. When the frame is complete and the display reader has released the other bank, the two banks swap. The LED-matrix scan driver reads only from the display bank, so it never sees a partially written frame.

## Interface
- ADDR_WIDTH, 11, width of pixel address within a frame; each bank holds 2^ADDR_WIDTH words
- DATA_WIDTH, 16, pixel word width
- CLK  in  1  single clock for all logic and both RAM ports
- RESET  in  1  reset, synchronous and active-high
- IN_DATA_VALID  in  1  write strobe from the cropper; one pixel per cycle
- IN_DATA_ADDR  in  ADDR_WIDTH  pixel address within the frame, from the cropper
- IN_DATA  in  DATA_WIDTH  pixel value, aligned with IN_DATA_VALID
- FRAME_LEN  in  ADDR_WIDTH+1  expected pixels per frame (IMAGE_WIDTH*IMAGE_HEIGHT); latched at each frame start
- FRAME_END  in  1  one-cycle pulse at end of source frame (vsync-derived)
- RD_REQ  in  1  display read request
- RD_ADDR  in  ADDR_WIDTH  display read address
- RD_RELEASE  in  1  one-cycle pulse: reader has finished with the display bank
- RD_DATA  out  DATA_WIDTH  read data
- RD_VALID  out  1  RD_DATA qualifier
- BANK_SEL  out  1  current display bank; the write bank is ~BANK_SEL
- FRAME_READY  out  1  one-cycle pulse, asserted in the cycle BANK_SEL toggles
- FRAME_ERR  out  1  one-cycle pulse: frame discarded on a count mismatch
- DROP_CNT  out  8  saturating count of discarded write strobes

## Operation
- States: FILL, WAIT_SWAP. Reset enters FILL.
- Internal registers:
  - wr_count: ADDR_WIDTH+1 bits
  - len_q: latched FRAME_LEN
  - rd_free: sticky flag, reset value 1, so the first complete frame swaps immediately
- Write acceptance (FILL only): IN_DATA_VALID && IN_DATA_ADDR < len_q writes IN_DATA to bank ~BANK_SEL at IN_DATA_ADDR and increments wr_count.
- Discarded strobes, each incrementing DROP_CNT (saturates at 255, cleared only by RESET):
  - a strobe with IN_DATA_ADDR >= len_q
  - any strobe while in WAIT_SWAP
- wr_count counts accepted strobes, not unique addresses.
- Effective count: eff = wr_count + (write accepted this cycle). A write coincident with FRAME_END is part of the frame.
- FRAME_END in FILL:
  - eff == len_q, len_q != 0 → frame complete. If rd_free (or RD_RELEASE this cycle), swap now; otherwise go to WAIT_SWAP.
  - otherwise → FRAME_ERR pulse; wr_count←0; re-latch len_q; stay in FILL; BANK_SEL unchanged.
- FRAME_END in WAIT_SWAP: ignored.
- RD_RELEASE sets rd_free. A swap consumes rd_free.
- Swap action:
  - BANK_SEL toggles, FRAME_READY=1, rd_free←0
  - wr_count←0, len_q←FRAME_LEN, state←FILL
- WAIT_SWAP with rd_free (set or arriving this cycle) → swap.
- Read port: on RD_REQ, bank BANK_SEL (value in the request cycle) at RD_ADDR is read.
- RAM contents are not reset.

## Timing
- Reset values:
  - BANK_SEL=0, FRAME_READY=0, FRAME_ERR=0, RD_VALID=0, RD_DATA=0, DROP_CNT=0
  - wr_count=0, rd_free=1, len_q←FRAME_LEN
- Write latency: data is in RAM after the accepting edge. Readable through the display bank only after the swap.
- Read latency: 1 cycle. RD_VALID and RD_DATA are registered and appear in the cycle after RD_REQ. RD_VALID=0 when there is no request.
- A swap in the same cycle as RD_REQ: that read returns pre-swap bank data. BANK_SEL changes on the next edge.
- FRAME_READY and FRAME_ERR are single-cycle and never asserted together.
- Swap timing: an eligible FRAME_END (rd_free=1) produces FRAME_READY and the new BANK_SEL one edge later.
- RESET mid-frame: partial frame abandoned, all registers reset, next frame starts clean in FILL.
- Back-to-back frames: writes in the cycle immediately after a swap go to the new write bank.

## Test plan
- FRAME_LEN=12; 12 strobes at addresses 0..11 with data 0x100+addr; FRAME_END with rd_free=1 → next cycle FRAME_READY=1, BANK_SEL=1. Then RD_REQ addrs 0..11 → RD_DATA 0x100..0x10B, each one cycle later.
- Second 12-pixel frame with no RD_RELEASE → state WAIT_SWAP; 5 extra strobes → DROP_CNT=5. RD_RELEASE arrives 10 cycles later → FRAME_READY pulses in the following cycle and BANK_SEL returns to 0.
- FRAME_LEN=12; only 9 strobes, then FRAME_END → FRAME_ERR pulse, BANK_SEL unchanged, wr_count=0, no FRAME_READY.
- 11 strobes, with the 12th strobe in the same cycle as FRAME_END → frame accepted and swapped. Strobe at address 12 with FRAME_LEN=12 → DROP_CNT+1, no write.
- RESET asserted after 6 of 12 strobes → all outputs at reset values next cycle. A following full 12-pixel frame swaps normally to BANK_SEL=1.
- FRAME_END coincident with RD_RELEASE while in WAIT_SWAP → exactly one swap and one FRAME_READY pulse. DROP_CNT saturates at 255 after 300 dropped strobes.

Source files
------------

// File: rtl/roi_frame_buffer.sv
// roi_frame_buffer: ping-pong ROI frame store between the cropper and the
// LED-matrix scan driver; the display bank only ever holds complete frames.
module roi_frame_buffer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_DATA_VALID,
  input  logic [ADDR_WIDTH-1:0] IN_DATA_ADDR,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [ADDR_WIDTH:0]   FRAME_LEN,
  input  logic                  FRAME_END,
  input  logic                  RD_REQ,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  input  logic                  RD_RELEASE,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  BANK_SEL,
  output logic                  FRAME_READY,
  output logic                  FRAME_ERR,
  output logic [7:0]            DROP_CNT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  rd_free_q, rd_free_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [DATA_WIDTH-1:0] mem_q [0:2*DEPTH-1];

  logic                wr_accept;
  logic                drop;
  logic [ADDR_WIDTH:0] eff;
  logic                frame_ok;
  logic                rel;
  logic                swap_go;
  logic                err_go;

  assign wr_accept = (state_q == FILL) && IN_DATA_VALID
                     && ({1'b0, IN_DATA_ADDR} < len_q);
  assign drop      = IN_DATA_VALID && !wr_accept;
  assign eff       = wr_count_q + {{ADDR_WIDTH{1'b0}}, wr_accept};
  assign frame_ok  = (eff == len_q) && (len_q != '0);
  assign rel       = rd_free_q | RD_RELEASE;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next state plus swap / error decisions.
  always_comb begin
    state_d = state_q;
    swap_go = 1'b0;
    err_go  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (FRAME_END) begin
          if (frame_ok) begin
            if (rel) swap_go = 1'b1;
            else     state_d = WAIT_SWAP;
          end else begin
            err_go = 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (rel) begin
          swap_go = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    wr_count_d    = eff;
    len_d         = len_q;
    bank_sel_d    = bank_sel_q;
    rd_free_d     = rel;
    frame_ready_d = 1'b0;
    frame_err_d   = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    rd_valid_d    = RD_REQ;
    rd_data_d     = rd_data_q;
    if (drop && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;
    if (RD_REQ)
      rd_data_d = mem_q[{bank_sel_q, RD_ADDR}];
    if (swap_go) begin
      bank_sel_d    = ~bank_sel_q;
      frame_ready_d = 1'b1;
      rd_free_d     = 1'b0;
      wr_count_d    = '0;
      len_d         = FRAME_LEN;
    end
    if (err_go) begin
      frame_err_d = 1'b1;
      wr_count_d  = '0;
      len_d       = FRAME_LEN;
    end
  end

  // Control and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_count_q    <= '0;
      len_q         <= FRAME_LEN;
      rd_free_q     <= 1'b1;
      bank_sel_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      drop_cnt_q    <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      len_q         <= len_d;
      rd_free_q     <= rd_free_d;
      bank_sel_q    <= bank_sel_d;
      frame_ready_q <= frame_ready_d;
      frame_err_q   <= frame_err_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Pixel writes into the bank not on display; contents never reset.
  always_ff @(posedge CLK) begin
    if (wr_accept && !RESET)
      mem_q[{~bank_sel_q, IN_DATA_ADDR}] <= IN_DATA;
  end

  assign RD_DATA     = rd_data_q;
  assign RD_VALID    = rd_valid_q;
  assign BANK_SEL    = bank_sel_q;
  assign FRAME_READY = frame_ready_q;
  assign FRAME_ERR   = frame_err_q;
  assign DROP_CNT    = drop_cnt_q;

endmodule
